axi4_csr_bank: RTL and testbench

Parametrised AXI4 slave register bank for the display TX controller and sibling IPs, and the generalised successor of the fixed 16×8-bit config register block. It supports a configurable register count and data width, byte write strobes, and INCR bursts. Each register has a selectable access type: read/write, read-only (status input), or write-pulse. The block sits between the AXI4 interconnect and IP control logic, driving flattened configuration outputs and one-cycle command pulses.

---
 rtl/axi4_csr_bank.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi4_csr_bank.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_csr_bank.sv
// AXI4 slave register bank: RW, read-only (status) and write-pulse registers, INCR bursts,
// byte strobes. Independent read and write FSMs.
module axi4_csr_bank #(
  parameter int unsigned                   ADDR_W           = 32,
  parameter logic [ADDR_W-1:0]             BASE_ADDR        = ADDR_W'(32'h3000_0000),
  parameter int unsigned                   REG_NUM          = 16,
  parameter int unsigned                   DATA_W           = 32,
  parameter int unsigned                   MST_ID_W         = 5,
  parameter int unsigned                   TRANS_DATA_LEN_W = 8,
  parameter int unsigned                   TRANS_RESP_W     = 2,
  parameter logic [REG_NUM-1:0]            RO_MASK          = '0,
  parameter logic [REG_NUM-1:0]            PULSE_MASK       = '0,
  parameter logic [REG_NUM*DATA_W-1:0]     RST_VAL          = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  // AW channel
  input  logic [MST_ID_W-1:0]           m_awid_i,
  input  logic [ADDR_W-1:0]             m_awaddr_i,
  input  logic [TRANS_DATA_LEN_W-1:0]   m_awlen_i,
  input  logic                          m_awvalid_i,
  output logic                          m_awready_o,
  // W channel
  input  logic [DATA_W-1:0]             m_wdata_i,
  input  logic [DATA_W/8-1:0]           m_wstrb_i,
  input  logic                          m_wlast_i,
  input  logic                          m_wvalid_i,
  output logic                          m_wready_o,
  // B channel
  output logic [MST_ID_W-1:0]           m_bid_o,
  output logic [TRANS_RESP_W-1:0]       m_bresp_o,
  output logic                          m_bvalid_o,
  input  logic                          m_bready_i,
  // AR channel
  input  logic [MST_ID_W-1:0]           m_arid_i,
  input  logic [ADDR_W-1:0]             m_araddr_i,
  input  logic [TRANS_DATA_LEN_W-1:0]   m_arlen_i,
  input  logic                          m_arvalid_i,
  output logic                          m_arready_o,
  // R channel
  output logic [MST_ID_W-1:0]           m_rid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic [TRANS_RESP_W-1:0]       m_rresp_o,
  output logic                          m_rlast_o,
  output logic                          m_rvalid_o,
  input  logic                          m_rready_i,
  // IP side
  input  logic [REG_NUM*DATA_W-1:0]     sts_i,
  output logic [REG_NUM*DATA_W-1:0]     cfg_o,
  output logic [REG_NUM-1:0]            pulse_o
);

  localparam int unsigned StrbW  = DATA_W / 8;
  localparam int unsigned IdxLsb = $clog2(StrbW);

  localparam logic [TRANS_RESP_W-1:0] RespOkay   = TRANS_RESP_W'(0);
  localparam logic [TRANS_RESP_W-1:0] RespSlvErr = TRANS_RESP_W'(2);
  localparam logic [TRANS_RESP_W-1:0] RespDecErr = TRANS_RESP_W'(3);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  function automatic logic [ADDR_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return off >> IdxLsb;
  endfunction

  // Base check and alignment only; the register-range check is redone per beat.
  function automatic logic addr_base_ok(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off & ADDR_W'(StrbW - 1)) == '0);
  endfunction

  w_state_e                        w_state_q, w_state_d;
  logic [MST_ID_W-1:0]             aw_id_q, aw_id_d;
  logic [ADDR_W-1:0]               w_idx_q, w_idx_d;
  logic                            w_base_ok_q, w_base_ok_d;
  logic [TRANS_DATA_LEN_W-1:0]     w_len_q, w_len_d;
  logic [TRANS_DATA_LEN_W-1:0]     w_cnt_q, w_cnt_d;
  logic [TRANS_RESP_W-1:0]         w_resp_q, w_resp_d;
  logic [TRANS_RESP_W-1:0]         beat_resp;
  logic [REG_NUM-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [REG_NUM-1:0]              pulse_q, pulse_d;

  r_state_e                        r_state_q, r_state_d;
  logic [MST_ID_W-1:0]             ar_id_q, ar_id_d;
  logic [ADDR_W-1:0]               r_idx_q, r_idx_d;
  logic                            r_base_ok_q, r_base_ok_d;
  logic [TRANS_DATA_LEN_W-1:0]     r_len_q, r_len_d;
  logic [TRANS_DATA_LEN_W-1:0]     r_cnt_q, r_cnt_d;

  logic w_ok, r_ok;
  logic unused_ok;

  assign unused_ok = ^{m_wlast_i, sts_i, regs_q};

  assign w_ok = w_base_ok_q && (w_idx_q < ADDR_W'(REG_NUM));
  assign r_ok = r_base_ok_q && (r_idx_q < ADDR_W'(REG_NUM));

  always_comb begin
    w_state_d   = w_state_q;
    aw_id_d     = aw_id_q;
    w_idx_d     = w_idx_q;
    w_base_ok_d = w_base_ok_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_resp_d    = w_resp_q;
    regs_d      = regs_q;
    pulse_d     = '0;
    beat_resp   = RespOkay;
    unique case (w_state_q)
      WIdle: begin
        if (m_awvalid_i) begin
          aw_id_d     = m_awid_i;
          w_idx_d     = addr_to_idx(m_awaddr_i);
          w_base_ok_d = addr_base_ok(m_awaddr_i);
          w_len_d     = m_awlen_i;
          w_cnt_d     = '0;
          w_resp_d    = RespOkay;
          w_state_d   = WData;
        end
      end
      WData: begin
        if (m_wvalid_i) begin
          if (!w_ok) begin
            beat_resp = RespDecErr;
          end else begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
              if (w_idx_q == ADDR_W'(i)) begin
                if (RO_MASK[i]) begin
                  beat_resp = RespSlvErr;
                end else if (PULSE_MASK[i]) begin
                  pulse_d[i] = |m_wstrb_i;
                end else begin
                  for (int b = 0; b < int'(StrbW); b++) begin
                    if (m_wstrb_i[b]) regs_d[i][8*b +: 8] = m_wdata_i[8*b +: 8];
                  end
                end
              end
            end
          end
          // Burst response is the worst (numerically highest) beat response.
          if (beat_resp > w_resp_q) w_resp_d = beat_resp;
          if (w_cnt_q == w_len_q) begin
            w_state_d = WResp;
          end else begin
            w_cnt_d = w_cnt_q + TRANS_DATA_LEN_W'(1);
            w_idx_d = w_idx_q + ADDR_W'(1);
          end
        end
      end
      WResp: begin
        if (m_bready_i) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    ar_id_d     = ar_id_q;
    r_idx_d     = r_idx_q;
    r_base_ok_d = r_base_ok_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    unique case (r_state_q)
      RIdle: begin
        if (m_arvalid_i) begin
          ar_id_d     = m_arid_i;
          r_idx_d     = addr_to_idx(m_araddr_i);
          r_base_ok_d = addr_base_ok(m_araddr_i);
          r_len_d     = m_arlen_i;
          r_cnt_d     = '0;
          r_state_d   = RData;
        end
      end
      RData: begin
        if (m_rready_i) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = RIdle;
          end else begin
            r_cnt_d = r_cnt_q + TRANS_DATA_LEN_W'(1);
            r_idx_d = r_idx_q + ADDR_W'(1);
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    m_rdata_o = '0;
    if (r_ok) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        if (r_idx_q == ADDR_W'(i)) begin
          if (RO_MASK[i])         m_rdata_o = sts_i[i*DATA_W +: DATA_W];
          else if (PULSE_MASK[i]) m_rdata_o = '0;
          else                    m_rdata_o = regs_q[i];
        end
      end
    end
  end

  always_comb begin
    cfg_o = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      if (!(RO_MASK[i] || PULSE_MASK[i])) cfg_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign m_awready_o = !rst && (w_state_q == WIdle);
  assign m_wready_o  = !rst && (w_state_q == WData);
  assign m_bvalid_o  = !rst && (w_state_q == WResp);
  assign m_bid_o     = aw_id_q;
  assign m_bresp_o   = w_resp_q;

  assign m_arready_o = !rst && (r_state_q == RIdle);
  assign m_rvalid_o  = !rst && (r_state_q == RData);
  assign m_rlast_o   = m_rvalid_o && (r_cnt_q == r_len_q);
  assign m_rid_o     = ar_id_q;
  assign m_rresp_o   = r_ok ? RespOkay : RespDecErr;

  assign pulse_o = rst ? '0 : pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= WIdle;
      aw_id_q     <= '0;
      w_idx_q     <= '0;
      w_base_ok_q <= 1'b0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_resp_q    <= RespOkay;
      regs_q      <= RST_VAL;
      pulse_q     <= '0;
      r_state_q   <= RIdle;
      ar_id_q     <= '0;
      r_idx_q     <= '0;
      r_base_ok_q <= 1'b0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
    end else begin
      w_state_q   <= w_state_d;
      aw_id_q     <= aw_id_d;
      w_idx_q     <= w_idx_d;
      w_base_ok_q <= w_base_ok_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      w_resp_q    <= w_resp_d;
      regs_q      <= regs_d;
      pulse_q     <= pulse_d;
      r_state_q   <= r_state_d;
      ar_id_q     <= ar_id_d;
      r_idx_q     <= r_idx_d;
      r_base_ok_q <= r_base_ok_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi4_csr_bank.sv
// Scoreboard bench for axi4_csr_bank: directed transactions push expected B/R responses,
// independent monitors pop and compare them.
module tb_axi4_csr_bank;

  localparam int unsigned NR = 16;
  localparam int unsigned DW = 32;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [NR-1:0] RO = 16'h0004;
  localparam logic [NR-1:0] PU = 16'h0020;

  function automatic logic [NR*DW-1:0] mk_rst();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < int'(NR); i++) v[i*DW +: DW] = 32'h1000_0000 | i;
    return v;
  endfunction

  localparam logic [NR*DW-1:0] RV = mk_rst();

  logic               clk = 1'b0;
  logic               rst;
  logic [4:0]         m_awid_i, m_arid_i;
  logic [31:0]        m_awaddr_i, m_araddr_i;
  logic [7:0]         m_awlen_i, m_arlen_i;
  logic               m_awvalid_i, m_arvalid_i, m_wvalid_i, m_wlast_i;
  logic [31:0]        m_wdata_i;
  logic [3:0]         m_wstrb_i;
  logic               m_bready_i, m_rready_i;
  logic               m_awready_o, m_wready_o, m_bvalid_o, m_arready_o, m_rvalid_o, m_rlast_o;
  logic [4:0]         m_bid_o, m_rid_o;
  logic [1:0]         m_bresp_o, m_rresp_o;
  logic [31:0]        m_rdata_o;
  logic [NR*DW-1:0]   sts_i, cfg_o;
  logic [NR-1:0]      pulse_o;

  int total = 0;
  int bad = 0;

  logic [6:0]  bq[$];
  logic [39:0] rq[$];
  logic [6:0]  b_exp;
  logic [39:0] r_exp;
  logic [31:0] wd[4];
  logic [3:0]  ws[4];
  logic [31:0] rd[4];
  logic [1:0]  rr[4];
  logic [NR*DW-1:0] exp_rst;

  always #5 clk = ~clk;

  axi4_csr_bank #(
    .ADDR_W(32), .BASE_ADDR(BASE), .REG_NUM(NR), .DATA_W(DW), .MST_ID_W(5),
    .TRANS_DATA_LEN_W(8), .TRANS_RESP_W(2), .RO_MASK(RO), .PULSE_MASK(PU), .RST_VAL(RV)
  ) dut (
    .clk(clk), .rst(rst),
    .m_awid_i(m_awid_i), .m_awaddr_i(m_awaddr_i), .m_awlen_i(m_awlen_i),
    .m_awvalid_i(m_awvalid_i), .m_awready_o(m_awready_o),
    .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i), .m_wlast_i(m_wlast_i),
    .m_wvalid_i(m_wvalid_i), .m_wready_o(m_wready_o),
    .m_bid_o(m_bid_o), .m_bresp_o(m_bresp_o), .m_bvalid_o(m_bvalid_o), .m_bready_i(m_bready_i),
    .m_arid_i(m_arid_i), .m_araddr_i(m_araddr_i), .m_arlen_i(m_arlen_i),
    .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o),
    .m_rid_o(m_rid_o), .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rlast_o(m_rlast_o),
    .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
    .sts_i(sts_i), .cfg_o(cfg_o), .pulse_o(pulse_o)
  );

  function automatic void check(input string nm, input logic [NR*DW-1:0] act,
                                input logic [NR*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && m_bvalid_o && m_bready_i) begin
      if (bq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_b got id=%0d resp=%0d required=none", m_bid_o, m_bresp_o);
      end else begin
        b_exp = bq.pop_front();
        check("b_id_resp", {m_bid_o, m_bresp_o}, b_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m_rvalid_o && m_rready_i) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_r got data=%0h required=none", m_rdata_o);
      end else begin
        r_exp = rq.pop_front();
        check("r_id_resp_last_data", {m_rid_o, m_rresp_o, m_rlast_o, m_rdata_o}, r_exp);
      end
    end
  end

  // ch: 0=AW, 1=W, 2=AR. Returns #1 after the handshake edge.
  task automatic wait_hs(input int ch);
    logic r;
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = (ch == 0) ? m_awready_o : (ch == 1) ? m_wready_o : m_arready_o;
      @(posedge clk);
      #1;
      if (r) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL handshake_timeout ch=%0d got=no_ready required=ready", ch);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [4:0] id,
                          input logic [1:0] bresp);
    bq.push_back({id, bresp});
    m_awaddr_i = addr; m_awlen_i = len; m_awid_i = id; m_awvalid_i = 1'b1;
    wait_hs(0);
    m_awvalid_i = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      m_wdata_i = wd[b]; m_wstrb_i = ws[b]; m_wlast_i = (b == int'(len)); m_wvalid_i = 1'b1;
      wait_hs(1);
    end
    m_wvalid_i = 1'b0;
    check("bvalid_latency", m_bvalid_o, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [4:0] id);
    for (int b = 0; b <= int'(len); b++) rq.push_back({id, rr[b], (b == int'(len)), rd[b]});
    m_araddr_i = addr; m_arlen_i = len; m_arid_i = id; m_arvalid_i = 1'b1;
    wait_hs(2);
    m_arvalid_i = 1'b0;
    check("rvalid_latency", m_rvalid_o, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (bq.size() == 0 && rq.size() == 0) break;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NR); i++) sts_i[i*DW +: DW] = 32'h5700_0000 | i;
    exp_rst = RV;
    exp_rst[2*DW +: DW] = '0;
    exp_rst[5*DW +: DW] = '0;
    rst = 1'b1;
    m_awid_i = '0; m_awaddr_i = '0; m_awlen_i = '0; m_awvalid_i = 1'b0;
    m_arid_i = '0; m_araddr_i = '0; m_arlen_i = '0; m_arvalid_i = 1'b0;
    m_wdata_i = '0; m_wstrb_i = '0; m_wlast_i = 1'b0; m_wvalid_i = 1'b0;
    m_bready_i = 1'b1; m_rready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {m_awready_o, m_wready_o, m_arready_o, m_bvalid_o, m_rvalid_o,
                          m_rlast_o, pulse_o}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {m_awready_o, m_arready_o, m_wready_o}, 3'b110);
    check("cfg_reset", cfg_o, exp_rst);
    @(posedge clk); #1;

    // RW write + readback (reg3)
    wd[0] = 32'hA5A5_1234; ws[0] = 4'hF;
    do_write(BASE + 32'hC, 8'd0, 5'd1, 2'b00);
    check("t1_cfg_reg3", cfg_o[127:96], 32'hA5A5_1234);
    drain();
    rd[0] = 32'hA5A5_1234; rr[0] = 2'b00;
    do_read(BASE + 32'hC, 8'd0, 5'd2);
    drain();

    // Partial strobe (reg6)
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(BASE + 32'h18, 8'd0, 5'd3, 2'b00);
    drain();
    wd[0] = 32'h0000_0000; ws[0] = 4'b0101;
    do_write(BASE + 32'h18, 8'd0, 5'd4, 2'b00);
    check("t2_cfg_reg6", cfg_o[6*DW +: DW], 32'hFF00_FF00);
    drain();
    rd[0] = 32'hFF00_FF00; rr[0] = 2'b00;
    do_read(BASE + 32'h18, 8'd0, 5'd5);
    drain();

    // INCR burst over the RO register 2
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333; wd[3] = 32'h4444_4444;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF; ws[3] = 4'hF;
    do_write(BASE, 8'd3, 5'd6, 2'b10);
    check("t3_cfg_0_3", cfg_o[127:0], {32'h4444_4444, 32'h0, 32'h2222_2222, 32'h1111_1111});
    drain();
    rd[0] = 32'h1111_1111; rd[1] = 32'h2222_2222; rd[2] = 32'h5700_0002; rd[3] = 32'h4444_4444;
    rr[0] = 2'b00; rr[1] = 2'b00; rr[2] = 2'b00; rr[3] = 2'b00;
    do_read(BASE, 8'd3, 5'd7);
    drain();

    // Pulse register 5
    wd[0] = 32'h0000_0001; ws[0] = 4'h1;
    do_write(BASE + 32'h14, 8'd0, 5'd8, 2'b00);
    check("t4_pulse_on", pulse_o, 16'h0020);
    @(posedge clk); #1;
    check("t4_pulse_off", pulse_o, 16'h0000);
    drain();
    rd[0] = 32'h0; rr[0] = 2'b00;
    do_read(BASE + 32'h14, 8'd0, 5'd9);
    drain();
    ws[0] = 4'h0;
    do_write(BASE + 32'h14, 8'd0, 5'd10, 2'b00);
    check("t4_no_pulse_zero_strb", pulse_o, 16'h0000);
    drain();

    // Misaligned address
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(BASE + 32'h2, 8'd0, 5'd11, 2'b11);
    check("t5_misaligned_nowrite", cfg_o[63:0], {32'h2222_2222, 32'h1111_1111});
    drain();
    rd[0] = 32'h0; rr[0] = 2'b11;
    do_read(BASE + 32'h2, 8'd0, 5'd12);
    drain();

    // Burst running off the end of the bank (reg14..)
    wd[0] = 32'hAAAA_0001; wd[1] = 32'hAAAA_0002; wd[2] = 32'hAAAA_0003; wd[3] = 32'hAAAA_0004;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF; ws[3] = 4'hF;
    do_write(BASE + 32'h38, 8'd3, 5'd13, 2'b11);
    check("t6_cfg_14_15", cfg_o[16*DW-1 : 14*DW], {32'hAAAA_0002, 32'hAAAA_0001});
    check("t6_no_wrap_reg0", cfg_o[31:0], 32'h1111_1111);
    drain();
    rd[0] = 32'hAAAA_0001; rd[1] = 32'hAAAA_0002; rd[2] = 32'h0; rd[3] = 32'h0;
    rr[0] = 2'b00; rr[1] = 2'b00; rr[2] = 2'b11; rr[3] = 2'b11;
    do_read(BASE + 32'h38, 8'd3, 5'd14);
    drain();

    // Below base
    rd[0] = 32'h0; rr[0] = 2'b11;
    do_read(32'h2FFF_FFFC, 8'd0, 5'd15);
    drain();

    // Reset in the middle of a write burst (reg8)
    m_awaddr_i = BASE + 32'h20; m_awlen_i = 8'd3; m_awid_i = 5'd16; m_awvalid_i = 1'b1;
    wait_hs(0);
    m_awvalid_i = 1'b0;
    m_wdata_i = 32'h7777_7777; m_wstrb_i = 4'hF; m_wvalid_i = 1'b1;
    wait_hs(1);
    check("t8_beat_written", cfg_o[8*DW +: DW], 32'h7777_7777);
    m_wvalid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t8_rst_outputs", {m_awready_o, m_wready_o, m_arready_o, m_bvalid_o}, 4'b0000);
    @(posedge clk); #1;
    check("t8_cfg_reload", cfg_o, exp_rst);
    rst = 1'b0;
    @(negedge clk);
    check("t8_ready_after_rst", {m_awready_o, m_arready_o, m_bvalid_o}, 3'b110);
    @(posedge clk); #1;

    // Concurrent read and write of reg1: read sees the old value
    wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
    rd[0] = 32'h1000_0001; rr[0] = 2'b00;
    fork
      do_write(BASE + 32'h4, 8'd0, 5'd17, 2'b00);
      do_read(BASE + 32'h4, 8'd0, 5'd18);
    join
    drain();
    rd[0] = 32'hCAFE_F00D;
    do_read(BASE + 32'h4, 8'd0, 5'd19);
    drain();

    repeat (3) @(posedge clk);
    check("b_queue_empty", bq.size(), 0);
    check("r_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
